// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
//   op_e     : operation selector (add / subtract)
//   nstage   : number of pipeline stages for a given width and slice width
//   width_ok : legality check used at elaboration time by the top level
package csa_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // One carry-select slice is resolved per pipeline stage.
  function automatic int unsigned nstage(input int unsigned width, input int unsigned block);
    return (block == 0) ? 0 : width / block;
  endfunction

  // WIDTH must be a non-zero multiple of BLOCK so every stage owns a full slice.
  function automatic bit width_ok(input int unsigned width, input int unsigned block);
    return (block != 0) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/csa_slice.sv
// Combinational BLOCK-bit carry-select slice.
// Two ripple-carry sums are formed in parallel, one assuming carry-in 0 and one assuming
// carry-in 1; the real carry-in only drives the final mux, so it never ripples through
// the slice.
//   a, b      : slice operands
//   cin       : carry into bit 0 of the slice
//   s         : selected slice sum
//   cout      : carry out of the slice MSB
//   c_msb_in  : carry into the slice MSB (used for signed overflow in the top slice)
module csa_slice
  import csa_pkg::*;
#(
  parameter int unsigned BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [BLOCK-1:0] s0, s1;
  logic [BLOCK:0]   c0, c1;

  always_comb begin
    s0    = '0;
    s1    = '0;
    c0    = '0;
    c1    = '0;
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (a[i] & c0[i]) | (b[i] & c0[i]);
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (a[i] & c1[i]) | (b[i] & c1[i]);
    end
  end

  assign s        = cin ? s1 : s0;
  assign cout     = cin ? c1[BLOCK] : c0[BLOCK];
  assign c_msb_in = cin ? c1[BLOCK-1] : c0[BLOCK-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Stage k resolves bits [k*BLOCK +: BLOCK] and registers the partial sum, the slice carry
// and the operands still to be processed. Stage 0 takes its operands straight from the
// input ports (after subtract inversion), so the pipe holds NSTAGE beats.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   : operand handshake; in_ready is combinational from out_ready
//   a, b, cin, sub        : operands; sub=1 computes a - b and ignores cin
//   out_valid / out_ready : result handshake
//   sum, cout, ovf, zero  : result and flags, held stable while stalled
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSTAGE = nstage(WIDTH, BLOCK);

  if (!width_ok(WIDTH, BLOCK)) begin : g_bad_width
    $error("csa_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  // Operand conditioning: subtraction is a + ~b + 1.
  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign op    = sub ? OP_SUB : OP_ADD;
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c0    = (op == OP_SUB) ? 1'b1 : cin;

  // Pipeline state.
  logic [NSTAGE-1:0] v_q;
  logic [NSTAGE-1:0] carry_q;
  logic [WIDTH-1:0]  sum_q [NSTAGE];
  logic [WIDTH-1:0]  a_q   [NSTAGE];
  logic [WIDTH-1:0]  b_q   [NSTAGE];
  logic              ovf_q, zero_q;

  // Per-stage inputs (from ports for stage 0, from the previous stage otherwise).
  logic [NSTAGE-1:0] v_st;
  logic [NSTAGE-1:0] c_st;
  logic [WIDTH-1:0]  a_st   [NSTAGE];
  logic [WIDTH-1:0]  b_st   [NSTAGE];
  logic [WIDTH-1:0]  sum_st [NSTAGE];

  // Slice results and the partial sum each stage would register.
  logic [BLOCK-1:0]  sl_s   [NSTAGE];
  logic [NSTAGE-1:0] sl_co;
  logic              sl_cm  [NSTAGE];
  logic [WIDTH-1:0]  sum_nx [NSTAGE];

  logic [NSTAGE-1:0] adv;

  // Advance chain: a stage may load when it is empty or its occupant moves on.
  // This ripples from out_ready down to in_ready in the same cycle.
  always_comb begin
    adv           = '0;
    adv[NSTAGE-1] = ~v_q[NSTAGE-1] | out_ready;
    for (int unsigned i = 1; i < NSTAGE; i++) begin
      adv[NSTAGE-1-i] = ~v_q[NSTAGE-1-i] | adv[NSTAGE-i];
    end
  end

  always_comb begin
    v_st      = '0;
    c_st      = '0;
    v_st[0]   = in_valid;
    c_st[0]   = c0;
    a_st[0]   = a;
    b_st[0]   = b_eff;
    sum_st[0] = '0;
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      v_st[k]   = v_q[k-1];
      c_st[k]   = carry_q[k-1];
      a_st[k]   = a_q[k-1];
      b_st[k]   = b_q[k-1];
      sum_st[k] = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    csa_slice #(
      .BLOCK (BLOCK)
    ) u_slice (
      .a        (a_st[k][k*BLOCK +: BLOCK]),
      .b        (b_st[k][k*BLOCK +: BLOCK]),
      .cin      (c_st[k]),
      .s        (sl_s[k]),
      .cout     (sl_co[k]),
      .c_msb_in (sl_cm[k])
    );
  end

  // Splice each stage's resolved slice into the partial sum it inherited.
  always_comb begin
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      sum_nx[k]                    = sum_st[k];
      sum_nx[k][k*BLOCK +: BLOCK]  = sl_s[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_st[k];
          // Bubbles do not load data, so a drained output keeps its last result.
          if (v_st[k]) begin
            sum_q[k]   <= sum_nx[k];
            carry_q[k] <= sl_co[k];
            a_q[k]     <= a_st[k];
            b_q[k]     <= b_st[k];
          end
        end
      end
      if (adv[NSTAGE-1] && v_st[NSTAGE-1]) begin
        ovf_q  <= sl_cm[NSTAGE-1] ^ sl_co[NSTAGE-1];
        zero_q <= ~|sum_nx[NSTAGE-1];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[NSTAGE-1];
  assign sum       = sum_q[NSTAGE-1];
  assign cout      = carry_q[NSTAGE-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed vectors on an 8-bit/4-bit-slice instance (latency 2),
// plus random valid/ready sweeps on 32/8 and 64/16 instances against a reference model.
module tb_csa_pipe_adder;

  logic clk;
  logic rst_n;
  logic rst_sw_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- 8-bit directed DUT
  logic       iv8, ir8, ov8, or8, ci8, sb8, co8, of8, zr8;
  logic [7:0] a8, b8, s8;

  csa_pipe_adder #(
    .WIDTH (8),
    .BLOCK (4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .cin       (ci8),
    .sub       (sb8),
    .out_valid (ov8),
    .out_ready (or8),
    .sum       (s8),
    .cout      (co8),
    .ovf       (of8),
    .zero      (zr8)
  );

  // One beat through an otherwise idle pipe; checks latency and every result field.
  task automatic do_vec(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic vs, input logic [7:0] es,
                        input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    a8 = va; b8 = vb; ci8 = vc; sb8 = vs; iv8 = 1'b1; or8 = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, ir8, 1);
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    check_eq({tag, "_lat1"}, ov8, 0);
    @(negedge clk);
    #1;
    check_eq({tag, "_vld"}, ov8, 1);
    check_eq({tag, "_sum"}, s8, es);
    check_eq({tag, "_cout"}, co8, ec);
    check_eq({tag, "_ovf"}, of8, eo);
    check_eq({tag, "_zero"}, zr8, ez);
  endtask

  // --------------------------------------------------------------- random sweep DUTs
  localparam int NBEATS = 10000;
  bit sweep_done [2];

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int unsigned W = (g == 0) ? 32 : 64;
    localparam int unsigned B = (g == 0) ? 8 : 16;

    logic         iv, ir, ov, orr, ci, sb, co, of, zr;
    logic [W-1:0] ra, rb, rs;
    logic [W+2:0] exp_q [$];

    csa_pipe_adder #(
      .WIDTH (W),
      .BLOCK (B)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_sw_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (ra),
      .b         (rb),
      .cin       (ci),
      .sub       (sb),
      .out_valid (ov),
      .out_ready (orr),
      .sum       (rs),
      .cout      (co),
      .ovf       (of),
      .zero      (zr)
    );

    initial begin
      int           accepted;
      int           popped;
      int           guard;
      logic [63:0]  r64;
      logic [W-1:0] be;
      logic [W:0]   full;
      logic         c0;
      logic         eovf;
      logic [W+2:0] e;
      accepted = 0;
      popped   = 0;
      guard    = 0;
      sweep_done[g] = 1'b0;
      iv = 1'b0; orr = 1'b0; ci = 1'b0; sb = 1'b0; ra = '0; rb = '0;
      wait (rst_sw_n === 1'b1);
      while ((accepted < NBEATS || exp_q.size() > 0) && guard < 60000) begin
        @(negedge clk);
        if (accepted < NBEATS) begin
          iv  = ($urandom_range(0, 3) != 0);
          orr = ($urandom_range(0, 3) != 0);
        end else begin
          iv  = 1'b0;
          orr = 1'b1;
        end
        r64 = {$urandom, $urandom};
        ra  = r64[W-1:0];
        r64 = {$urandom, $urandom};
        rb  = r64[W-1:0];
        ci  = $urandom_range(0, 1) != 0;
        sb  = $urandom_range(0, 1) != 0;
        if ($urandom_range(0, 7) == 0) begin
          rb = ra;
          sb = 1'b1;
        end
        #1;
        if (ov && orr) begin
          if (exp_q.size() == 0) begin
            check_eq("sweep_unexpected_out", ov, 0);
          end else begin
            e = exp_q.pop_front();
            popped++;
            check_eq("sweep_result", {of, co, zr, rs}, e);
          end
        end
        if (iv && ir) begin
          be   = sb ? ~rb : rb;
          c0   = sb | ci;
          full = {1'b0, ra} + {1'b0, be} + {{W{1'b0}}, c0};
          eovf = (ra[W-1] == be[W-1]) && (full[W-1] != ra[W-1]);
          exp_q.push_back({eovf, full[W], ~|full[W-1:0], full[W-1:0]});
          accepted++;
        end
        guard++;
      end
      check_eq("sweep_accepted", accepted, NBEATS);
      check_eq("sweep_delivered", popped, NBEATS);
      check_eq("sweep_leftover", exp_q.size(), 0);
      sweep_done[g] = 1'b1;
    end
  end

  // ------------------------------------------------------------------------ main
  logic [7:0]  ba [4];
  logic [7:0]  bb [4];
  logic        bs [4];
  logic [10:0] bx [4];

  initial begin
    int fi;
    int w;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; rst_sw_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sb8 = 1'b0;

    // {ovf, cout, zero, sum} for the backpressure beats.
    ba[0] = 8'h01; bb[0] = 8'h02; bs[0] = 1'b0; bx[0] = 11'h003;
    ba[1] = 8'hFF; bb[1] = 8'h01; bs[1] = 1'b0; bx[1] = 11'h300;
    ba[2] = 8'h7F; bb[2] = 8'h01; bs[2] = 1'b0; bx[2] = 11'h480;
    ba[3] = 8'h10; bb[3] = 8'h20; bs[3] = 1'b1; bx[3] = 11'h0F0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", ov8, 0);
    check_eq("rst_in_ready", ir8, 1);
    check_eq("rst_sum", s8, 0);
    check_eq("rst_cout", co8, 0);
    check_eq("rst_ovf", of8, 0);
    check_eq("rst_zero", zr8, 0);
    rst_n = 1'b1;
    rst_sw_n = 1'b1;

    do_vec("add", 8'h96, 8'h71, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0);
    do_vec("add_cin", 8'h96, 8'h71, 1'b1, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0);
    do_vec("add_ovf", 8'h54, 8'h35, 1'b1, 1'b0, 8'h8A, 1'b0, 1'b1, 1'b0);
    do_vec("sub_borrow", 8'h00, 8'h24, 1'b0, 1'b1, 8'hDC, 1'b0, 1'b0, 1'b0);
    do_vec("sub_zero", 8'h24, 8'h24, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    do_vec("sub_cin_ign", 8'h24, 8'h24, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    do_vec("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Backpressure: fill with out_ready low, then drain at one result per cycle.
    fi = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      or8 = (cyc >= 4);
      if (fi < 4) begin
        iv8 = 1'b1; a8 = ba[fi]; b8 = bb[fi]; sb8 = bs[fi]; ci8 = 1'b0;
      end else begin
        iv8 = 1'b0;
      end
      #1;
      if (cyc < 2) check_eq("bp_ready", ir8, 1);
      if (cyc == 2) check_eq("bp_accepts", fi, 2);
      if (cyc == 2 || cyc == 3) begin
        check_eq("bp_full", ir8, 0);
        check_eq("bp_hold", {of8, co8, zr8, s8}, bx[0]);
      end
      if (cyc == 4) check_eq("bp_accept_and_emit", ir8, 1);
      if (cyc >= 4 && cyc <= 7) begin
        check_eq("bp_drain_valid", ov8, 1);
        check_eq("bp_drain", {of8, co8, zr8, s8}, bx[cyc-4]);
      end
      if (cyc == 8) check_eq("bp_empty", ov8, 0);
      if (iv8 && ir8) fi++;
    end

    // Reset with two beats in flight.
    @(negedge clk);
    iv8 = 1'b1; or8 = 1'b1; a8 = ba[0]; b8 = bb[0]; sb8 = 1'b0;
    @(negedge clk);
    a8 = ba[1]; b8 = bb[1];
    @(negedge clk);
    iv8 = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_out_valid", ov8, 0);
    check_eq("rst_mid_sum", s8, 0);
    check_eq("rst_mid_in_ready", ir8, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("rst_mid_no_partial", ov8, 0);
    do_vec("post_rst", 8'h96, 8'h71, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0);

    w = 0;
    while (!(sweep_done[0] && sweep_done[1]) && w < 80000) begin
      @(negedge clk);
      w++;
    end
    check_eq("sweep_finished", {sweep_done[0], sweep_done[1]}, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
